// File: rtl/modport_mem_pkg.sv
// ============================================================================
// Module   : modport_mem_pkg
// Purpose  : Shared defaults and types for the modport_mem data memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package modport_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 256;

    typedef logic [DATA_W_DEF-1:0] word_t;

    localparam int IDX_W = $clog2(DEPTH_DEF);

endpackage

`default_nettype wire

// File: rtl/modport_mem_array.sv
// ============================================================================
// Module   : modport_mem_array
// Purpose  : Word storage with async clear, one write port, two comb reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module modport_mem_array
    import modport_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    localparam int C_IDX_W   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic [C_IDX_W-1:0]    i_wr_idx,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [C_IDX_W-1:0]    i_rd_idx_a,
    input  logic [C_IDX_W-1:0]    i_rd_idx_b,
    output logic [DATA_WIDTH-1:0] o_rd_data_a,
    output logic [DATA_WIDTH-1:0] o_rd_data_b
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Whole array clears the instant reset drops, so a pending write is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wdata;
        end
    end

    assign o_rd_data_a = r_mem[i_rd_idx_a];
    assign o_rd_data_b = r_mem[i_rd_idx_b];

endmodule

`default_nettype wire

// File: rtl/modport_mem.sv
// ============================================================================
// Module   : modport_mem
// Purpose  : Data memory returning words addr and addr+1, registered (lat 1).
//            Define MEM_WRITE_FWD_EN for write-first forwarding on collision.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module modport_mem
    import modport_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] rdata2
);

    localparam int              C_IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH:0]   w_addr_ext;
    logic [ADDR_WIDTH:0]   w_addr_p1;
    logic                  w_in_range;
    logic                  w_in_range_p1;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_rdata2;

    // One extra bit so addr+1 never wraps back into range.
    assign w_addr_ext    = {1'b0, addr};
    assign w_addr_p1     = w_addr_ext + 1'b1;
    assign w_in_range    = (w_addr_ext < C_DEPTH);
    assign w_in_range_p1 = (w_addr_p1 < C_DEPTH);

    modport_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk         (clk),
        .reset       (reset),
        .i_wr_en     (wr_en && w_in_range),
        .i_wr_idx    (addr[C_IDX_W-1:0]),
        .i_wdata     (wdata),
        .i_rd_idx_a  (addr[C_IDX_W-1:0]),
        .i_rd_idx_b  (w_addr_p1[C_IDX_W-1:0]),
        .o_rd_data_a (w_rd_a),
        .o_rd_data_b (w_rd_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata  <= '0;
            r_rdata2 <= '0;
        end else if (rd_en) begin
`ifdef MEM_WRITE_FWD_EN
            if (wr_en && w_in_range) begin
                r_rdata <= wdata;
            end else begin
                r_rdata <= w_in_range ? w_rd_a : '0;
            end
`else
            r_rdata  <= w_in_range ? w_rd_a : '0;
`endif
            r_rdata2 <= w_in_range_p1 ? w_rd_b : '0;
        end
    end

    assign rdata  = r_rdata;
    assign rdata2 = r_rdata2;

endmodule

`default_nettype wire

// File: tb/tb_modport_mem.sv
// ============================================================================
// Module   : tb_modport_mem
// Purpose  : Scoreboard bench for modport_mem (honours MEM_WRITE_FWD_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modport_mem;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] rdata2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp1_q [$];
    logic [31:0] exp2_q [$];
    logic [31:0] addr_q [$];

    modport_mem u_dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .wdata  (wdata),
        .rdata  (rdata),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr_en = 1'b1; rd_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e1, input logic [31:0] e2);
        @(negedge clk);
        addr = a; wr_en = 1'b0; rd_en = 1'b1;
        exp1_q.push_back(e1); exp2_q.push_back(e2); addr_q.push_back(a);
    endtask

    task automatic wrrd(input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] e1, input logic [31:0] e2);
        @(negedge clk);
        addr = a; wdata = d; wr_en = 1'b1; rd_en = 1'b1;
        exp1_q.push_back(e1); exp2_q.push_back(e2); addr_q.push_back(a);
    endtask

    task automatic idle(input logic [31:0] a);
        @(negedge clk);
        addr = a; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    // Every accepted read strobe is scored one cycle later against the queue.
    always @(posedge clk) begin
        if (reset && rd_en) begin
            #1;
            if (exp1_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow: got read with empty scoreboard");
            end else begin
                logic [31:0] a, e1, e2;
                a  = addr_q.pop_front();
                e1 = exp1_q.pop_front();
                e2 = exp2_q.pop_front();
                check($sformatf("rd@%0d rdata", a), rdata, e1);
                check($sformatf("rd@%0d rdata2", a), rdata2, e2);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_col;
`ifdef MEM_WRITE_FWD_EN
        exp_col = 32'h2;
`else
        exp_col = 32'h1;
`endif
        reset = 1'b0; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
        #3;
        check("reset rdata", rdata, 32'h0);
        check("reset rdata2", rdata2, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Write/read and hold
        wr(10, 32'hDEADBEEF);
        wr(11, 32'h12345678);
        rd(10, 32'hDEADBEEF, 32'h12345678);
        idle(20);
        @(negedge clk);
        check("hold rdata", rdata, 32'hDEADBEEF);
        check("hold rdata2", rdata2, 32'h12345678);
        @(negedge clk);
        check("hold2 rdata", rdata, 32'hDEADBEEF);
        check("hold2 rdata2", rdata2, 32'h12345678);

        // Boundary and out-of-range
        wr(255, 32'hA5A5A5A5);
        rd(255, 32'hA5A5A5A5, 32'h0);
        rd(254, 32'h0, 32'hA5A5A5A5);
        wr(300, 32'hFFFFFFFF);
        rd(300, 32'h0, 32'h0);
        rd(44, 32'h0, 32'h0);

        // Collision
        wr(7, 32'h1);
        wrrd(7, 32'h2, exp_col, 32'h0);
        rd(7, 32'h2, 32'h0);

        // Back-to-back reads
        wr(0, 32'h100);
        wr(1, 32'h101);
        wr(2, 32'h102);
        wr(3, 32'h103);
        rd(0, 32'h100, 32'h101);
        rd(1, 32'h101, 32'h102);
        rd(2, 32'h102, 32'h103);

        // Reset mid-operation, with a write pending into the reset window
        wr(5, 32'h55);
        rd(4, 32'h0, 32'h55);
        idle(0);
        @(negedge clk);
        wr_en = 1'b1; addr = 6; wdata = 32'h66;
        #2;
        reset = 1'b0;
        #1;
        check("async rst rdata", rdata, 32'h0);
        check("async rst rdata2", rdata2, 32'h0);
        @(negedge clk);
        wr_en = 1'b0;
        reset = 1'b1;
        rd(5, 32'h0, 32'h0);
        rd(10, 32'h0, 32'h0);
        idle(0);
        idle(0);
        @(negedge clk);

        check("sb drained", 32'(exp1_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/modport_mem.md
Name: modport_mem

Overview:
- Single-port-write, dual-word-read synchronous data memory used as the data memory of the single-cycle (monociclo) CPU.
- Driven through the codebase memory interface: addr, wr_en, rd_en, wdata in; rdata, rdata2 out.
- A read returns the word at addr on rdata and the next word (addr+1) on rdata2, both registered.

Parameters:
- ADDR_WIDTH, 32, width of addr.
- DATA_WIDTH, 32, width of wdata/rdata/rdata2.
- DEPTH, 256, number of words stored; must be a power of two ≥ 2.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  ADDR_WIDTH  word address (word-addressed, not byte).
- wr_en  input  1  write strobe.
- rd_en  input  1  read strobe.
- wdata  input  DATA_WIDTH  write data.
- rdata  output  DATA_WIDTH  registered word at addr.
- rdata2  output  DATA_WIDTH  registered word at addr+1.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, named reset.
  - reset low forces rdata=0, rdata2=0 and all DEPTH words to 0 immediately.
  - Operation resumes on the first rising clk edge after reset is high.
- Write: on posedge with wr_en=1 and addr<DEPTH, mem[addr] <= wdata. Writes with addr≥DEPTH are ignored.
- Read timing: on posedge with rd_en=1, the registers load, so data is valid one cycle after the strobe (latency 1):
  - rdata <= (addr<DEPTH) ? mem[addr] : 0
  - rdata2 <= (addr+1<DEPTH) ? mem[addr+1] : 0
  - Compute addr+1 with one extra bit. There is no wrap-around: the last word's rdata2 is 0.
- rd_en=0: rdata and rdata2 hold their previous values.
- Simultaneous wr_en and rd_en, same cycle: read-before-write. rdata/rdata2 return contents prior to this write (unless MEM_WRITE_FWD_EN is defined).
- wr_en and rd_en both 0: no state change.
- Reset asserted mid-operation: a pending write is lost, and outputs and memory are zero.
- No handshake or backpressure; every strobe completes in one cycle. X on addr with a strobe set is a bench error, not handled.

Optional Feature:
- Macro: MEM_WRITE_FWD_EN.
- Defined: write-first forwarding. When wr_en=1, rd_en=1 and addr<DEPTH in the same cycle, rdata <= wdata (new data). rdata2 is unaffected, because addr+1 never equals the write address.
- Undefined: read-before-write as above.

Decomposition:
- Package modport_mem_pkg holds:
  - default width constants ADDR_W_DEF=32, DATA_W_DEF=32, DEPTH_DEF=256;
  - typedef word_t (logic [DATA_W_DEF-1:0]);
  - localparam IDX_W = $clog2(DEPTH_DEF).
- Optional sub-module modport_mem_array: storage with async clear, one write port and two combinational read ports. The top adds range checks and the output registers.

Test Plan:
- Reset: drive reset=0 mid-run after writes -> rdata=0, rdata2=0 at once; a read of addr 5 after release returns 0/0.
- Write/read: write 0xDEADBEEF@10 and 0x12345678@11, then rd_en@10 -> next cycle rdata=0xDEADBEEF, rdata2=0x12345678.
- Hold: after the read above, drive rd_en=0 and addr=20 -> rdata/rdata2 stay 0xDEADBEEF/0x12345678.
- Boundary: write 0xA5A5A5A5@255, read@255 -> rdata=0xA5A5A5A5, rdata2=0. Write@300 ignored; read@300 -> 0/0.
- Collision: mem[7]=0x1, then same cycle wr_en+rd_en@7 with wdata=0x2:
  - without MEM_WRITE_FWD_EN -> rdata=0x1;
  - with MEM_WRITE_FWD_EN -> rdata=0x2;
  - either way, a later read@7 -> 0x2.
- Back-to-back: reads at addrs 0,1,2 on consecutive cycles after writing 0x100,0x101,0x102,0x103 -> rdata/rdata2 pairs (0x100,0x101), (0x101,0x102), (0x102,0x103), one cycle after each strobe.
